// File: rtl/fir_pkg.sv
// fir_pkg: widths shared by the FIR front end and its MAC stage, the sequencer
// state encoding, and a modulo decrement helper for delay-line indexing.
package fir_pkg;

   localparam int COEF_W = 18;
   localparam int SAMP_W = 36;
   localparam int ACC_W  = 53;

   typedef logic [2:0] seq_state_t;

   localparam seq_state_t ST_IDLE  = 3'd0;
   localparam seq_state_t ST_CLEAR = 3'd1;
   localparam seq_state_t ST_RUN   = 3'd2;
   localparam seq_state_t ST_DRAIN = 3'd3;
   localparam seq_state_t ST_OUT   = 3'd4;

   // Step an index one place back in a ring of n entries. The compare-and-
   // reload form keeps the wrap correct when n is not a power of two.
   function automatic logic [8:0] mod_dec(input logic [8:0] idx, input logic [8:0] n);
      logic [8:0] r;
      if (idx == 9'd0) begin
         r = n - 9'd1;
      end else begin
         r = idx - 9'd1;
      end
      return r;
   endfunction

endpackage

// File: rtl/fir_sample_ring.sv
// fir_sample_ring: circular delay line of NTAPS input samples.
// Ports:
//   clock, reset   - system clock, synchronous active-high reset
//   wr_en, wr_data - store wr_data at the current write pointer
//   advance        - move the write pointer on by one (mod NTAPS)
//   rd_idx/rd_data - combinational read of any entry
//   wr_ptr         - current write pointer (slot of the next sample)
module fir_sample_ring
   import fir_pkg::*;
#(
   parameter int NTAPS = 16,
   parameter int AW    = 4
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [SAMP_W-1:0] wr_data,
   input  logic              advance,
   input  logic [AW-1:0]     rd_idx,
   output logic [SAMP_W-1:0] rd_data,
   output logic [AW-1:0]     wr_ptr
);

   localparam logic [AW-1:0] LAST_IDX = AW'(NTAPS - 1);

   logic [SAMP_W-1:0] line_r [NTAPS];
   logic [AW-1:0]     wr_ptr_r;

   // Sample storage and write pointer; reset zeroes the whole history.
   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < NTAPS; i++) begin
            line_r[i] <= '0;
         end
         wr_ptr_r <= '0;
      end else begin
         if (wr_en) begin
            line_r[wr_ptr_r] <= wr_data;
         end
         if (advance) begin
            if (wr_ptr_r == LAST_IDX) begin
               wr_ptr_r <= '0;
            end else begin
               wr_ptr_r <= wr_ptr_r + AW'(1);
            end
         end
      end
   end

   assign rd_data = line_r[rd_idx];
   assign wr_ptr  = wr_ptr_r;

endmodule

// File: rtl/fir_tap_sequencer.sv
// fir_tap_sequencer: front-end controller for the 18x36 FIR MAC stage.
// Accepts one sample per in_valid/in_ready handshake, clears the MAC,
// streams NTAPS coefficient/sample pairs (newest sample first), waits
// MAC_LAT cycles, then presents mac_out on out_data with out_valid/out_ready.
// Ports:
//   clock, reset                      - clock, synchronous active-high reset
//   in_valid/in_ready/in_sample       - input sample handshake
//   coef_wr_en/addr/data              - coefficient write port (idle only)
//   mac_clear, mac_a, mac_b, mac_out  - MAC control, operands and result
//   out_valid/out_ready/out_data      - filter output handshake
module fir_tap_sequencer
   import fir_pkg::*;
#(
   parameter int NTAPS   = 16,
   parameter int MAC_LAT = 4,
   parameter int AW      = 4
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [SAMP_W-1:0] in_sample,
   input  logic              coef_wr_en,
   input  logic [AW-1:0]     coef_wr_addr,
   input  logic [COEF_W-1:0] coef_wr_data,
   output logic              mac_clear,
   output logic [COEF_W-1:0] mac_a,
   output logic [SAMP_W-1:0] mac_b,
   input  logic [ACC_W-1:0]  mac_out,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  out_data
);

   localparam logic [AW:0] NTAPS_C    = (AW+1)'(NTAPS);
   localparam logic [7:0]  DRAIN_LAST = 8'(MAC_LAT - 1);

   seq_state_t        state_r;
   logic [AW:0]       tap_r;        // next tap to present
   logic [AW-1:0]     idx_r;        // delay-line slot of the next tap
   logic [7:0]        drain_cnt_r;
   logic [COEF_W-1:0] coef_r [NTAPS];
   logic [COEF_W-1:0] coef_rd_s;
   logic [SAMP_W-1:0] samp_rd_s;
   logic [AW-1:0]     wr_ptr_s;
   logic              accept_s;
   logic              advance_s;
   logic              coef_we_s;

   fir_sample_ring #(.NTAPS(NTAPS), .AW(AW)) u_ring (
      .clock   (clock),
      .reset   (reset),
      .wr_en   (accept_s),
      .wr_data (in_sample),
      .advance (advance_s),
      .rd_idx  (idx_r),
      .rd_data (samp_rd_s),
      .wr_ptr  (wr_ptr_s)
   );

   // Handshake decode, coefficient write qualification and coefficient read.
   always_comb begin
      accept_s  = (state_r == ST_IDLE) && in_ready && in_valid;
      advance_s = (state_r == ST_OUT) && out_valid && out_ready;
      // Writes land only while idle and never in the cycle a sample is taken.
      coef_we_s = !reset && (state_r == ST_IDLE) && !accept_s && coef_wr_en &&
                  ({1'b0, coef_wr_addr} < NTAPS_C);
      if (tap_r < NTAPS_C) begin
         coef_rd_s = coef_r[tap_r[AW-1:0]];
      end else begin
         coef_rd_s = '0;
      end
   end

   // Coefficient registers; intentionally not reset.
   always_ff @(posedge clock) begin
      if (coef_we_s) begin
         coef_r[coef_wr_addr] <= coef_wr_data;
      end
   end

   // Sequencer FSM; all outputs are registered and take the value that
   // belongs to the state being entered.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         tap_r       <= '0;
         idx_r       <= '0;
         drain_cnt_r <= 8'd0;
         in_ready    <= 1'b0;
         mac_clear   <= 1'b1;
         mac_a       <= '0;
         mac_b       <= '0;
         out_valid   <= 1'b0;
         out_data    <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               mac_a <= '0;
               mac_b <= '0;
               if (accept_s) begin
                  in_ready  <= 1'b0;
                  mac_clear <= 1'b1;
                  idx_r     <= wr_ptr_s;
                  tap_r     <= '0;
                  state_r   <= ST_CLEAR;
               end else begin
                  in_ready  <= 1'b1;
                  mac_clear <= 1'b0;
               end
            end
            // CLEAR presents tap 0 for the first RUN cycle; RUN presents the
            // following taps until all NTAPS have been issued.
            ST_CLEAR, ST_RUN: begin
               mac_clear <= 1'b0;
               if (tap_r == NTAPS_C) begin
                  mac_a       <= '0;
                  mac_b       <= '0;
                  drain_cnt_r <= 8'd0;
                  state_r     <= ST_DRAIN;
               end else begin
                  mac_a   <= coef_rd_s;
                  mac_b   <= samp_rd_s;
                  tap_r   <= tap_r + (AW+1)'(1);
                  idx_r   <= AW'(mod_dec(9'(idx_r), 9'(NTAPS)));
                  state_r <= ST_RUN;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt_r == DRAIN_LAST) begin
                  out_data  <= mac_out;
                  out_valid <= 1'b1;
                  state_r   <= ST_OUT;
               end else begin
                  drain_cnt_r <= drain_cnt_r + 8'd1;
               end
            end
            ST_OUT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state_r   <= ST_IDLE;
               end else begin
                  out_valid <= 1'b1;
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               in_ready  <= 1'b0;
               mac_clear <= 1'b1;
               mac_a     <= '0;
               mac_b     <= '0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer (NTAPS=5, MAC_LAT=4) with a behavioural MAC
// attached and a queue-based convolution reference model.
module tb_fir_tap_sequencer;

   localparam int NTAPS   = 5;
   localparam int MAC_LAT = 4;
   localparam int AW      = 3;
   localparam int LAT     = NTAPS + MAC_LAT + 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [35:0] in_sample = 36'd0;
   logic        coef_wr_en = 1'b0;
   logic [2:0]  coef_wr_addr = 3'd0;
   logic [17:0] coef_wr_data = 18'd0;
   logic        mac_clear;
   logic [17:0] mac_a;
   logic [35:0] mac_b;
   logic [52:0] mac_out;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [52:0] out_data;

   int total = 0;
   int bad   = 0;

   always #5 clock = ~clock;

   fir_tap_sequencer #(.NTAPS(NTAPS), .MAC_LAT(MAC_LAT), .AW(AW)) dut (
      .clock        (clock),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sample    (in_sample),
      .coef_wr_en   (coef_wr_en),
      .coef_wr_addr (coef_wr_addr),
      .coef_wr_data (coef_wr_data),
      .mac_clear    (mac_clear),
      .mac_a        (mac_a),
      .mac_b        (mac_b),
      .mac_out      (mac_out),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data)
   );

   // Behavioural MAC: accumulator plus MAC_LAT-1 output pipeline stages.
   logic signed [52:0] ea, eb, acc;
   logic signed [52:0] pipe [MAC_LAT-1];
   assign ea = $signed(mac_a);
   assign eb = $signed(mac_b);
   always @(posedge clock) begin
      if (mac_clear) acc <= '0;
      else           acc <= acc + ea * eb;
      pipe[0] <= acc;
      for (int i = 1; i < MAC_LAT - 1; i++) pipe[i] <= pipe[i-1];
   end
   assign mac_out = pipe[MAC_LAT-2];

   // Reference model: coefficient table and newest-first sample history.
   logic signed [17:0] coef_m [NTAPS];
   logic signed [35:0] hist [$];

   function automatic logic [52:0] model_out();
      logic signed [52:0] s, c, h;
      s = '0;
      for (int k = 0; k < hist.size(); k++) begin
         c = coef_m[k];
         h = hist[k];
         s = s + c * h;
      end
      return s;
   endfunction

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
      end
   endtask

   task automatic write_coef(input int addr, input logic [17:0] data);
      coef_wr_addr = 3'(addr);
      coef_wr_data = data;
      coef_wr_en   = 1'b1;
      @(negedge clock);
      coef_wr_en   = 1'b0;
      if (addr < NTAPS) coef_m[addr] = data;
   endtask

   // mode 0: plain; 1: in_valid held and coef write during RUN; 2: coef write with accept
   task automatic send(input logic [35:0] s, input int hold, input int mode, output logic [52:0] got);
      int n;
      bit ok;
      logic [52:0] want, held;
      n = 0;
      while (in_ready !== 1'b1 && n < 50) begin
         @(negedge clock);
         n++;
      end
      check_val("in_ready_idle", 64'(in_ready), 64'd1);
      in_sample = s;
      in_valid  = 1'b1;
      if (mode == 2) begin
         coef_wr_addr = 3'd0;
         coef_wr_data = 18'd77;
         coef_wr_en   = 1'b1;
      end
      @(negedge clock);
      coef_wr_en = 1'b0;
      in_valid   = 1'b0;
      in_sample  = ~s;
      hist.push_front(s);
      if (hist.size() > NTAPS) void'(hist.pop_back());
      want = model_out();
      n  = 1;
      ok = 1'b1;
      while (out_valid !== 1'b1 && n < 200) begin
         if (in_ready !== 1'b0) ok = 1'b0;
         in_valid = (mode == 1);
         if (mode == 1 && n == 3) begin
            coef_wr_addr = 3'd0;
            coef_wr_data = 18'd77;
            coef_wr_en   = 1'b1;
         end else begin
            coef_wr_en = 1'b0;
         end
         @(negedge clock);
         n++;
      end
      coef_wr_en = 1'b0;
      in_valid   = 1'b0;
      check_val("busy_in_ready_low", 64'(ok), 64'd1);
      check_val("latency", 64'(n), 64'(LAT));
      held = out_data;
      ok = 1'b1;
      if (mac_a !== 18'd0 || mac_b !== 36'd0) ok = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clock);
         if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 ||
             mac_a !== 18'd0 || mac_b !== 36'd0) ok = 1'b0;
      end
      check_val("out_hold_stable", 64'(ok), 64'd1);
      got = out_data;
      check_val("out_data", 64'(out_data), 64'(want));
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      check_val("single_transfer", 64'(out_valid), 64'd0);
      check_val("in_ready_after", 64'(in_ready), 64'd1);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [52:0] g;
      logic [63:0] r;
      logic [52:0] imp_exp [6];
      bit ok;
      imp_exp[0] = 53'd1; imp_exp[1] = 53'd2; imp_exp[2] = 53'd3;
      imp_exp[3] = 53'd4; imp_exp[4] = 53'd5; imp_exp[5] = 53'd0;

      // reset state
      repeat (3) @(negedge clock);
      check_val("rst_in_ready", 64'(in_ready), 64'd0);
      check_val("rst_mac_clear", 64'(mac_clear), 64'd1);
      check_val("rst_out_valid", 64'(out_valid), 64'd0);
      check_val("rst_mac_a", 64'(mac_a), 64'd0);
      check_val("rst_mac_b", 64'(mac_b), 64'd0);
      check_val("rst_out_data", 64'(out_data), 64'd0);
      reset = 1'b0;
      @(negedge clock);
      check_val("in_ready_rise", 64'(in_ready), 64'd1);

      // impulse response; out-of-range coefficient writes are dropped
      for (int k = 0; k < NTAPS; k++) write_coef(k, 18'(k + 1));
      write_coef(5, 18'd99);
      write_coef(7, 18'd99);
      for (int k = 0; k < 6; k++) begin
         send((k == 0) ? 36'd1 : 36'd0, 0, 0, g);
         check_val("impulse", 64'(g), 64'(imp_exp[k]));
      end

      // sign extremes with 20 cycles of backpressure
      write_coef(0, 18'h20000);
      for (int k = 1; k < NTAPS; k++) write_coef(k, 18'd0);
      send(36'h8_0000_0000, 20, 0, g);
      check_val("sign_extreme", 64'(g), 64'h0010_0000_0000_0000);

      // wrap-around with unit coefficients
      for (int k = 0; k < NTAPS; k++) write_coef(k, 18'd1);
      for (int s = 1; s <= 12; s++) send(36'(s), 0, 0, g);
      check_val("wrap_sum", 64'(g), 64'd50);

      // coefficient writes while busy / at accept are ignored
      send(36'd13, 0, 1, g);
      check_val("busy_coef_ignored", 64'(g), 64'd55);
      send(36'd14, 0, 2, g);
      check_val("accept_coef_ignored", 64'(g), 64'd60);

      // reset in RUN at tap k=2
      for (int k = 0; k < NTAPS; k++) write_coef(k, 18'(k + 1));
      in_sample = 36'd3;
      in_valid  = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      repeat (3) @(negedge clock);
      check_val("run_k2_coef", 64'(mac_a), 64'd3);
      reset = 1'b1;
      @(negedge clock);
      check_val("midrst_mac_clear", 64'(mac_clear), 64'd1);
      check_val("midrst_out_valid", 64'(out_valid), 64'd0);
      check_val("midrst_in_ready", 64'(in_ready), 64'd0);
      check_val("midrst_mac_b", 64'(mac_b), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      hist.delete();
      ok = 1'b1;
      repeat (15) begin
         @(negedge clock);
         if (out_valid !== 1'b0) ok = 1'b0;
      end
      check_val("midrst_no_output", 64'(ok), 64'd1);
      for (int k = 0; k < 6; k++) begin
         send((k == 0) ? 36'd1 : 36'd0, 0, 0, g);
         check_val("impulse_after_rst", 64'(g), 64'(imp_exp[k]));
      end

      // randomized traffic against the reference model
      for (int it = 0; it < 30; it++) begin
         if ($urandom_range(0, 2) == 0) begin
            r = {$urandom, $urandom};
            write_coef($urandom_range(0, 7), r[17:0]);
         end
         r = {$urandom, $urandom};
         send(r[35:0], $urandom_range(0, 3), $urandom_range(0, 2), g);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fir_tap_sequencer.md
Name: fir_tap_sequencer

Overview:
- Front-end controller for the 18x36 MAC stage of the FIR datapath.
- Accepts one 36-bit input sample per handshake and stores it in a circular delay line of NTAPS samples.
- For each sample: clears the MAC, streams NTAPS coefficient/sample pairs into it, waits out the MAC pipeline, then captures the 53-bit accumulated result as one filter output with a valid/ready handshake.

Parameters:
- NTAPS, 16, number of filter taps; delay-line and coefficient-memory depth (2..256).
- MAC_LAT, 4, cycles from the last pair presented to the MAC until its result is stable at mac_out.
- AW, 4, address width = ceil(log2(NTAPS)).

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  sequencer can accept a sample.
- in_sample  in  36  signed input sample.
- coef_wr_en  in  1  coefficient write strobe.
- coef_wr_addr  in  AW  tap index for the coefficient write.
- coef_wr_data  in  18  signed coefficient.
- mac_clear  out  1  drives the MAC's synchronous reset.
- mac_a  out  18  signed coefficient operand to the MAC.
- mac_b  out  36  signed sample operand to the MAC.
- mac_out  in  53  signed accumulated MAC result.
- out_valid  out  1  filter output valid.
- out_ready  in  1  downstream accepts the output.
- out_data  out  53  signed filter output.

Behaviour:
- Reset values:
  - Registered outputs: in_ready=0, mac_clear=1, mac_a=0, mac_b=0, out_valid=0, out_data=0.
  - State = IDLE, wr_ptr=0, all delay-line entries zero.
  - Coefficients are not cleared; they stay undefined until written.
  - in_ready rises on the first cycle after reset deasserts.
- States: IDLE -> CLEAR -> RUN -> DRAIN -> OUT -> IDLE.
- IDLE:
  - in_ready=1, mac_a=mac_b=0.
  - On in_valid&in_ready: write in_sample to line[wr_ptr], latch base=wr_ptr, go to CLEAR.
- CLEAR (1 cycle): mac_clear=1, operands 0.
- RUN (NTAPS cycles, tap index k=0..NTAPS-1):
  - mac_a=coef[k], mac_b=line[(base-k) mod NTAPS].
  - k=0 presents the newest sample.
  - Go to DRAIN after k=NTAPS-1.
- DRAIN (MAC_LAT cycles): operands 0. The MAC accumulates every cycle, so idle operands must always be zero.
- OUT:
  - out_data is latched from mac_out on the DRAIN->OUT edge, out_valid=1.
  - Both are held stable until out_ready.
  - On out_valid&out_ready: wr_ptr=(wr_ptr+1) mod NTAPS, out_valid=0, go to IDLE.
- in_ready=0 in every state except IDLE. in_valid outside IDLE is ignored.
- Latency: accept in cycle 0 -> out_valid in cycle NTAPS+MAC_LAT+2 (22 for the defaults). With out_ready held high, throughput is one sample per NTAPS+MAC_LAT+3 cycles.
- Coefficient writes:
  - Honoured only in IDLE.
  - Ignored in all other states, including the same cycle as a sample accept.
  - Addresses >= NTAPS are ignored.
- Wrap-around: wr_ptr and (base-k) wrap modulo NTAPS. This holds for NTAPS not a power of two: compare and subtract, no bit truncation.
- Arithmetic: the block does no arithmetic on data; out_data is mac_out bit-exact. MAC overflow wraps mod 2^53 and is not flagged.
- Reset mid-operation (any state):
  - Everything returns to reset values, including delay-line contents.
  - A pending out_valid is dropped.
  - mac_clear=1 keeps the MAC cleared.
- Zero-initialised delay line: the first NTAPS-1 outputs see zero history (start-up transient).

Decomposition:
- Package fir_pkg:
  - COEF_W=18, SAMP_W=36, ACC_W=53 (shared with the MAC stage).
  - Sequencer state enum.
  - Function for the modulo-NTAPS decrement.
- Sub-module fir_sample_ring:
  - Delay-line RAM with write port and combinational read by index.
  - Owns wr_ptr and the reset-to-zero behaviour.
- Coefficient storage: a plain register array inside the sequencer.

Test Plan:
- Impulse:
  - Setup: NTAPS=4, coefficients {1,2,3,4}.
  - Stimulus: samples 1,0,0,0,0.
  - Expect: outputs 1,2,3,4,0, first out_valid exactly 10 cycles after accept (MAC_LAT=4), with the real MAC attached.
- Sign extremes:
  - Stimulus: coef[0]=-131072, sample=-2^35, other coefficients 0.
  - Expect: out_data=2^52 mod 2^53, i.e. the 53-bit wrapped value 0x10000000000000 (no saturation).
- Backpressure:
  - Stimulus: out_ready low for 20 cycles.
  - Expect: out_valid/out_data stable, in_ready=0 throughout, no MAC operands nonzero; one transfer when out_ready rises.
- Wrap-around:
  - Setup: NTAPS=5, all coefficients 1.
  - Stimulus: samples 1..12.
  - Expect: output n = sum of the last 5 samples (e.g. sample 12 -> 50).
- Coefficient write while busy:
  - Stimulus: coef_wr_en during RUN.
  - Expect: coefficient unchanged; the next output still uses the old value.
- Reset mid-RUN:
  - Stimulus: reset at RUN k=2.
  - Expect: mac_clear=1, no out_valid, and the next impulse response matches the fresh-start case.
